// File: rtl/hack_fetch.sv
// hack_fetch: HACK CPU instruction fetch front-end with a prefetch FIFO.
// Optional perf counters (stall_cycles, flush_count) under HACK_FETCH_PERF_EN.
module hack_fetch #(
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic        pc_increment,
    input  logic        flush,
    output logic        rom_en,
    output logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic [15:0] instr_addr,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef HACK_FETCH_PERF_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

    logic [0:0]             state;
    logic [ROM_LATENCY-1:0] fl_valid;
    logic [15:0]            fl_addr [ROM_LATENCY];
    logic [15:0]            mem_data [FIFO_DEPTH];
    logic [15:0]            mem_addr [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          used;
    logic                   pop;
    logic                   push;
    logic                   issue;

    assign pop  = instr_valid && instr_ready;
    assign push = fl_valid[ROM_LATENCY-1] && !flush;

    // Outstanding ROM requests still travelling down the latency pipe
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(fl_valid[i]);
        end
    end

    // Credits: every issued word has a FIFO slot reserved when it returns
    always_comb begin
        used  = inflight + CW'(count) - CW'(pop);
        issue = (state == RUN) && !flush && (used < CW'(FIFO_DEPTH));
    end

    assign rom_en       = issue;
    assign pc_increment = issue;
    assign rom_addr     = pc[14:0];
    assign instr_valid  = (count != '0);
    assign instr        = mem_data[rd_ptr];
    assign instr_addr   = mem_addr[rd_ptr];

    // IDLE lasts one cycle so the PC settles; flush also lands in RUN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= RUN;
        end
    end

    // Latency pipe tagging each request with the PC it was fetched from
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fl_valid <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                fl_addr[i] <= '0;
            end
        end else begin
            fl_valid[0] <= issue;
            fl_addr[0]  <= pc;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                fl_valid[i] <= fl_valid[i-1] && !flush;
                fl_addr[i]  <= fl_addr[i-1];
            end
        end
    end

    // Prefetch FIFO; a flush drops every buffered word and any pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= rom_data;
                mem_addr[wr_ptr] <= fl_addr[ROM_LATENCY-1];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef HACK_FETCH_PERF_EN
    // Saturating counters for idle RUN cycles and taken jumps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (state == RUN && !issue && !flush &&
                stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/hack_fetch.md
Name: hack_fetch

Overview:
Instruction fetch front-end for the HACK CPU. It consumes the program-counter value, drives the instruction ROM with a fixed-latency read, and buffers returned instructions in a small prefetch FIFO. Instructions are presented to decode with a valid/ready handshake. It drives the increment control back to the PC and discards buffered and in-flight words when a jump flushes the pipeline.

Parameters:
ROM_LATENCY, 1, cycles from rom_en to valid rom_data; legal 1..4.
FIFO_DEPTH, 2, prefetch entries; power of two, >= 2. Full throughput requires FIFO_DEPTH >= ROM_LATENCY+1.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
pc  input  16  current PC value from the program counter.
pc_increment  output  1  advance PC this cycle; combinational, equals rom_en.
flush  input  1  jump taken; PC is loaded with the target on this same edge.
rom_en  output  1  ROM read request.
rom_addr  output  15  ROM word address, pc[14:0].
rom_data  input  16  ROM read data, valid ROM_LATENCY cycles after rom_en.
instr  output  16  instruction at the FIFO head.
instr_addr  output  16  PC value the head instruction was fetched from.
instr_valid  output  1  FIFO non-empty.
instr_ready  input  1  decode accepts head; pop when valid && ready.

Behaviour:
- Reset (async) values:
  - state=IDLE; FIFO empty; in-flight pipe cleared.
  - instr_valid=0, rom_en=0, pc_increment=0.
  - instr, instr_addr = 0.
- FSM states:
  - IDLE: one cycle after reset release, no issue, so the PC reset value settles. Then go to RUN.
  - RUN: normal operation.
  - flush in any state: go to RUN.
- Issue rule (RUN only):
  - Condition: !flush && (inflight + occupancy - pop) < FIFO_DEPTH, where pop = instr_valid && instr_ready.
  - On issue: rom_en=1, rom_addr=pc[14:0], pc_increment=1, all in the same cycle.
- In-flight tracking:
  - ROM_LATENCY-stage shift register of {valid, addr[15:0]}.
  - A request issued in cycle t is pushed into the FIFO at the end of cycle t+ROM_LATENCY, capturing rom_data.
  - instr_valid rises in cycle t+ROM_LATENCY+1.
- Credit rule guarantees no FIFO overflow. Push and pop in the same cycle are legal at full and at empty.
  - At empty, the pushed word becomes visible next cycle; no bypass.
- FIFO empty: instr_valid=0. instr and instr_addr hold their last values and are don't-care.
- Backpressure: instr_ready=0 holds the head stable. Issue stops when credits run out; no word is lost or duplicated.
- Flush cycle:
  - No issue.
  - FIFO occupancy cleared; any pop in this cycle is ignored.
  - All in-flight valid bits cleared; a rom_data return in this cycle is dropped.
  - Next cycle issues from the new pc (the jump target).
- Address wrap:
  - rom_addr uses pc[14:0], so pc 0x7FFF→0x8000 wraps rom_addr to 0.
  - instr_addr carries the full 16-bit pc.
- Reset mid-operation: immediate return to reset values; in-flight ROM returns after reset are ignored.
- Ordering: instructions are delivered strictly in issue order.

Optional Feature:
HACK_FETCH_PERF_EN:
- Defined:
  - Adds outputs stall_cycles[15:0] and flush_count[15:0], both saturating counters, reset to 0.
  - stall_cycles increments each RUN cycle with no issue and no flush.
  - flush_count increments each cycle flush=1.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset: assert reset mid-stream with 1 word buffered → next cycle instr_valid=0, rom_en=0, instr=0. After release, one IDLE cycle, then rom_en=1 with rom_addr=0.
- Streaming (defaults): pc from 0, ROM returns addr^16'hA5A5, instr_ready=1 → instr=0xA5A5,0xA5A4,0xA5A7… one per cycle. First instr_valid 3 cycles after reset release.
- Backpressure: instr_ready=0 for 6 cycles → exactly 2 issues, then pc_increment=0. On ready=1, addresses 0,1,2 arrive contiguous with no gaps or duplicates.
- Flush: words 4,5 buffered, 6 in flight, flush with PC loaded to 0x0100 → words 4,5,6 never appear. Next instr_addr=0x0100, valid 2 cycles after the first issue.
- Wrap: pc=0x7FFF then 0x8000 → rom_addr 0x7FFF then 0x0000; instr_addr 0x7FFF, 0x8000.
- ROM_LATENCY=3, FIFO_DEPTH=4, ready=1 → sustained one instr per cycle. With FIFO_DEPTH=2, throughput is 1 per 2 cycles and there is no overflow.
